// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared declarations for the MIPS instruction-memory loader:
//               loader state encoding, IM address width default, word width
//               and a big-endian byte placement helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int IM_ADDR_W = 10;
  localparam int WORD_W    = 32;

  // ST_CHECK is only reachable when IM_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_CHECK = 2'd3
  } ldr_state_e;

  // Merge byte number idx (0 = first = MSB) into a partially built word.
  // Unfilled bytes are known to be zero, so an OR is enough.
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx,
                                                   input logic [7:0]        b);
    logic [4:0] sh;
    sh = {~idx, 3'b000};  // 8 * (3 - idx)
    return word | ({24'd0, b} << sh);
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Collects bytes into a big-endian 32-bit word. Reports when
//               the current push completes a word (4th byte or last byte).
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_push          - a byte is transferred this cycle
//               i_data, i_last  - byte value and end-of-image flag
//               i_clear         - drop the assembled word and byte index
//               o_word_next     - word including the byte on i_data
//               o_complete      - this push closes a word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [7:0]        i_data,
  input  logic              i_last,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_word_next,
  output logic              o_complete
);

  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_word;

  assign o_word_next = place_byte(r_word, r_idx, i_data);
  assign o_complete  = i_push && ((r_idx == 2'd3) || i_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= 2'd0;
      r_word <= '0;
    end else if (i_push) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= o_word_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// ============================================================================
// Module      : im_loader
// Description : Streams a byte image into the instruction memory as
//               big-endian words from address 0 and holds the CPU in reset
//               until the image is complete.
// Ports       : clock, reset (async, active-low), start (restart in DONE)
//               in_valid/in_data/in_last/in_ready - byte stream handshake
//               im_we/im_addr/im_wdata            - IM write port
//               cpu_hold, load_done, word_count, ovf - status
//               chk_err (IM_LOADER_CHECKSUM_EN only) - trailer mismatch
// Config      : IM_LOADER_CHECKSUM_EN - image ends with a 4-byte big-endian
//               trailer holding the modulo-2^32 sum of the written words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              ovf
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic              chk_err
`endif
);

  ldr_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_in_ready;
  logic              r_im_we;
  logic [ADDR_W-1:0] r_im_addr;
  logic [WORD_W-1:0] r_im_wdata;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_ovf;
  logic              r_close_last;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
  logic [WORD_W-1:0] r_trailer;
  logic              r_chk_err;
`endif

  logic              w_xfer;
  logic              w_complete;
  logic              w_clear;
  logic              w_full;
  logic [WORD_W-1:0] w_word_next;

  assign w_xfer  = in_valid && r_in_ready;
  assign w_clear = (r_state != ST_LOAD);
  // Count has one extra bit; its MSB set means all 2**ADDR_W words are used.
  assign w_full  = r_count[ADDR_W];

  byte_packer u_packer (
    .clk         (clock),
    .rst_n       (reset),
    .i_push      (w_xfer),
    .i_data      (in_data),
    .i_last      (in_last),
    .i_clear     (w_clear),
    .o_word_next (w_word_next),
    .o_complete  (w_complete)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_LOAD;
      r_addr       <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b1;
      r_im_we      <= 1'b0;
      r_im_addr    <= '0;
      r_im_wdata   <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_ovf        <= 1'b0;
      r_close_last <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
      r_trailer    <= '0;
      r_chk_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_complete) begin
            r_in_ready   <= 1'b0;
            r_close_last <= in_last;
`ifdef IM_LOADER_CHECKSUM_EN
            if (in_last) begin
              r_state   <= ST_CHECK;
              r_trailer <= w_word_next;
            end else
`endif
            begin
              r_state <= ST_WRITE;
              // Write strobe is set up on the transfer edge so it is a
              // clean register output during the WRITE cycle.
              if (!w_full) begin
                r_im_we    <= 1'b1;
                r_im_addr  <= r_addr;
                r_im_wdata <= w_word_next;
              end
            end
          end
        end

        ST_WRITE: begin
          r_im_we <= 1'b0;
          // r_im_we doubles as "this word was actually stored".
          if (r_im_we) begin
            r_addr  <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + r_im_wdata;
`endif
          end else begin
            r_ovf <= 1'b1;
          end
          if (r_close_last) begin
            r_state     <= ST_DONE;
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b1;
          end else begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
          end
        end

`ifdef IM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          r_chk_err   <= (r_sum != r_trailer);
          r_state     <= ST_DONE;
          r_cpu_hold  <= 1'b0;
          r_load_done <= 1'b1;
        end
`endif

        ST_DONE: begin
          if (start) begin
            r_state     <= ST_LOAD;
            r_in_ready  <= 1'b1;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_addr      <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_chk_err   <= 1'b0;
`endif
          end
        end

        default: begin
          r_state    <= ST_LOAD;
          r_in_ready <= 1'b1;
          r_im_we    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign im_we      = r_im_we;
  assign im_addr    = r_im_addr;
  assign im_wdata   = r_im_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign word_count = r_count;
  assign ovf        = r_ovf;
`ifdef IM_LOADER_CHECKSUM_EN
  assign chk_err    = r_chk_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// Module      : tb_im_loader
// Description : Randomised scoreboard bench for im_loader. Expected IM
//               writes are derived from each byte image and queued; a
//               negedge monitor pops and compares every im_we pulse and
//               tracks handshake/status outputs. Honours the
//               IM_LOADER_CHECKSUM_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_im_loader;

  localparam int AW  = 3;
  localparam int CAP = 1 << AW;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          ovf;
`ifdef IM_LOADER_CHECKSUM_EN
  logic          chk_err;
`endif

  always #5 clock = ~clock;

  im_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .word_count (word_count),
    .ovf        (ovf)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // --------------------------------------------------------------------
  // Monitor: handshake-level model of the loader (bytes per word, done
  // flag) plus scoreboard pop on every write strobe.
  // --------------------------------------------------------------------
  logic m_done = 1'b0;
  logic m_wr   = 1'b0;   // next sample is the cycle after a word closed
  logic m_wr_last = 1'b0;
  int   m_idx  = 0;

  always @(negedge clock) begin
    logic nd, nw;
    wr_t  e;
    if (!reset) begin
      m_done = 1'b0; m_wr = 1'b0; m_wr_last = 1'b0; m_idx = 0;
    end
    chk("in_ready", in_ready, !(m_done || m_wr));
    chk("cpu_hold", cpu_hold, !m_done);
    chk("load_done", load_done, m_done);
    if (im_we) begin
      chk("im_we_in_write_cycle", m_wr, 1'b1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("im_addr", im_addr, e.addr);
        chk("im_wdata", im_wdata, e.data);
      end
    end
    if (reset) begin
      nd = m_done ? !start : (m_wr && m_wr_last);
      nw = 1'b0;
      if (!m_done && !m_wr && in_valid) begin
        if (m_idx == 3 || in_last) begin
          nw = 1'b1; m_wr_last = in_last; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      m_done = nd;
      m_wr   = nw;
    end
  end

  // --------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b1; in_data = b; in_last = last;
    for (int t = 0; ; t++) begin
      @(negedge clock);
      if (in_ready) break;
      if (t > 20) begin chk("ready_timeout", 0, 1); break; end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  // Build expected writes from the image, stream it, then check status.
  task automatic run_image(input byte_q_t img, input bit gaps);
    int          nbytes, nwords, exp_wc;
    logic [31:0] w, sum;
    wr_t         e;
    bit          got_done;
    nbytes = img.size();
`ifdef IM_LOADER_CHECKSUM_EN
    nbytes = nbytes - 4;
`endif
    nwords = (nbytes + 3) / 4;
    sum = 0;
    for (int i = 0; i < nwords; i++) begin
      w = 0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < nbytes) w[31-8*k -: 8] = img[4*i + k];
      if (i < CAP) begin
        e.addr = AW'(i); e.data = w;
        exp_q.push_back(e);
        sum = sum + w;
      end
    end
    exp_wc = (nwords < CAP) ? nwords : CAP;
    for (int i = 0; i < img.size(); i++)
      send_byte(img[i], i == img.size() - 1, gaps);
    got_done = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (load_done) begin got_done = 1; break; end
    end
    chk("done_reached", got_done, 1);
    chk("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    chk("word_count", word_count, exp_wc);
    chk("ovf", ovf, nwords > CAP);
`ifdef IM_LOADER_CHECKSUM_EN
    begin
      logic [31:0] tr;
      tr = {img[nbytes], img[nbytes+1], img[nbytes+2], img[nbytes+3]};
      chk("chk_err", chk_err, sum != tr);
    end
`endif
  endtask

  initial begin
    byte_q_t img;
    logic [31:0] s, v;
    int nw;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clock); #1; reset = 1'b1;

`ifndef IM_LOADER_CHECKSUM_EN
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    run_image(img, 0);
    pulse_start();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_image(img, 0);
    // More words than the memory holds: the extras set ovf.
    pulse_start();
    img = {};
    for (int i = 0; i < 4*(CAP+2); i++) img.push_back(8'($urandom));
    run_image(img, 1);
    // Random image lengths, including partial final words and overflow.
    for (int r = 0; r < 8; r++) begin
      pulse_start();
      img = {};
      repeat ($urandom_range(1, (r == 7) ? 45 : 30)) img.push_back(8'($urandom));
      run_image(img, 1);
    end
`else
    img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h00, 8'h00, 8'h00, 8'h03};
    run_image(img, 0);
    pulse_start();
    img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h00, 8'h00, 8'h00, 8'h04};
    run_image(img, 0);
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      img = {};
      s = 0;
      nw = $urandom_range(1, CAP);
      for (int i = 0; i < nw; i++) begin
        v = $urandom;
        s = s + v;
        for (int k = 0; k < 4; k++) img.push_back(v[31-8*k -: 8]);
      end
      if ($urandom_range(0, 1) == 1) s = s + 32'd1;
      for (int k = 0; k < 4; k++) img.push_back(s[31-8*k -: 8]);
      run_image(img, 1);
    end
`endif

    // Reset in the middle of a word: partial bytes are discarded.
    pulse_start();
    send_byte(8'h55, 0, 0);
    send_byte(8'h66, 0, 0);
    @(posedge clock); #3; reset = 1'b0;
    #1;
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_im_we", im_we, 0);
    chk("midrst_word_count", word_count, 0);
    @(posedge clock); #1; reset = 1'b1;
`ifndef IM_LOADER_CHECKSUM_EN
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
`else
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
    run_image(img, 0);

    // start is ignored outside DONE.
    pulse_start();
    send_byte(8'h99, 0, 0);
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(negedge clock);
    chk("start_ignored_load_done", load_done, 0);
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/im_loader.md
# im_loader

Program loader that sits directly upstream of the `mips` core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them sequentially into the IM `rom` from word 0 and holds the core in reset until the program is complete. It replaces `$readmemh` preloading, so the same image can be delivered by a bench or by a UART/debug front end.

## Interface
- `ADDR_W`, 10, IM word-address width; capacity is 2**ADDR_W words.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; in DONE, begins a new load from word 0. Ignored in other states.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  program byte.
- `in_last`  in  1  qualifies the final byte of the image.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `im_we`  out  1  IM write strobe, one cycle per word.
- `im_addr`  out  ADDR_W  IM word address.
- `im_wdata`  out  32  IM write data.
- `cpu_hold`  out  1  active-high; drives the core's reset; high in every state except DONE.
- `load_done`  out  1  high in DONE.
- `word_count`  out  ADDR_W+1  words written in the current load.
- `ovf`  out  1  sticky; a word completed with the memory already full.

## Operation
- A byte is transferred when `in_valid && in_ready`.
- States: LOAD, WRITE, DONE.
  - Reset → LOAD. Byte index 0, address 0, count 0, `ovf` 0.
- LOAD:
  - `in_ready`=1. Byte k (0..3) is placed in bits [31-8k -: 8] of the assembly register, so the first byte is the MSB.
  - Go to WRITE on the 4th byte, or on any transferred byte with `in_last`=1.
  - Unfilled low bytes of a partial word are zero.
- WRITE (one cycle):
  - `in_ready`=0.
  - If count < 2**ADDR_W: `im_we`=1, `im_addr`=address, `im_wdata`=assembled word. Then address+1 and count+1, with address wrapping modulo 2**ADDR_W.
  - Else: no write and `ovf`←1.
  - Clear assembly register and byte index.
  - Next state is DONE if the word was closed by `in_last`, else LOAD.
- DONE:
  - `in_ready`=0, `cpu_hold`=0, `load_done`=1.
  - `start` → LOAD with address, count, index and `ovf` cleared.
- `in_last` with zero bytes pending cannot occur, because `in_last` always rides on a transferred byte.
- Bytes arriving after the memory is full are still accepted and assembled, then dropped at WRITE.
- `start` outside DONE has no effect.

## Timing
- Reset values:
  - `in_ready`=1, `im_we`=0, `im_addr`=0, `im_wdata`=0.
  - `cpu_hold`=1, `load_done`=0, `word_count`=0, `ovf`=0.
- Latency: the write occurs in the cycle after the 4th (or last) byte's transfer edge. `im_we` is registered.
- Throughput: 4 bytes per 5 cycles at best, because `in_ready` drops for the WRITE cycle.
- `cpu_hold` falls on the clock edge entering DONE. The core starts fetching at PC reset value on the next edge.
- `reset` asserted mid-load aborts immediately. Partial data is discarded and `cpu_hold` is 1 asynchronously. IM contents already written are not cleared.

## Configuration
- `IM_LOADER_CHECKSUM_EN` defined:
  - The image is followed by a 4-byte big-endian trailer. `in_last` sits on the trailer's final byte, not on program data.
  - The loader keeps a 32-bit modulo-2^32 sum of all written words.
  - Extra state CHECK collects the trailer without writing IM.
  - Extra output `chk_err` (1 bit, reset 0, cleared by `start`) is set on entry to DONE when sum ≠ trailer.
  - Because the trailer exists, program words use only the 4-byte boundary; a partial word before the trailer is not supported.
- Not defined: no trailer, no sum, no `chk_err` port. Behaviour is exactly as above.

## Structure
- Shared package `mips_pkg`:
  - state enum for the loader;
  - `IM_ADDR_W` default (10);
  - `WORD_W` = 32.
- One sub-module: `byte_packer`, which holds the byte index and shift/assembly register and signals word-complete. The FSM, address and count stay in `im_loader`.

## Test plan
- Stream bytes 20 08 00 05, 20 09 00 07 with `in_last` on the final byte. Required:
  - two `im_we` pulses: addr 0 = 0x20080005, addr 1 = 0x20090007;
  - `word_count`=2; `cpu_hold` falls; `load_done`=1.
- 6 bytes AA BB CC DD 11 22, last on 0x22. Required: addr 1 = 0x11220000, then DONE.
- `ADDR_W`=2, send 5 full words. Required:
  - four writes at addr 0..3; fifth word not written;
  - `ovf`=1, `word_count`=4.
- Toggle `in_valid` randomly. Required:
  - no byte lost or duplicated;
  - `in_ready`=0 exactly in WRITE cycles and in DONE.
- Assert `reset` after 2 bytes, release, then send 4 bytes 01 02 03 04 last. Required: single write addr 0 = 0x01020304.
- With `IM_LOADER_CHECKSUM_EN`:
  - words 0x00000001, 0x00000002 with trailer 00 00 00 03: `chk_err`=0;
  - same words with trailer 00 00 00 04: `chk_err`=1.
